player_ctrl: RTL and testbench

Controller that sequences the player-ship datapath. It turns raw joystick codes and the fire button into rate-limited, bounds-checked one-cycle move commands for the player datapath. It also runs a fire request/acknowledge handshake with the bullet unit, followed by a frame-counted cooldown. It sits between the input-sampling logic and the player/bullet datapaths, and is paced by the VGA frame tick.

---
 rtl/player_ctrl_if.sv | 42 ++++
 rtl/player_ctrl.sv | 147 ++++++++++++++
 tb/tb_player_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/player_ctrl_if.sv
// Signal bundle between the player controller, the input-sampling logic
// and the player/bullet datapaths.
interface player_ctrl_if;
    logic [3:0] Joystick_data;
    logic       Fire_btn;
    logic       Frame_tick;
    logic [9:0] Player_Col;
    logic       Bullet_ack;
    logic       Move_left;
    logic       Move_right;
    logic       Fire_req;
    logic [9:0] Fire_col;
    logic       Fire_ready;

    // Controller side: consumes inputs, issues move pulses and shot requests
    modport master (
        input  Joystick_data,
        input  Fire_btn,
        input  Frame_tick,
        input  Player_Col,
        input  Bullet_ack,
        output Move_left,
        output Move_right,
        output Fire_req,
        output Fire_col,
        output Fire_ready
    );

    // Surrounding logic side: drives inputs, observes controller outputs
    modport slave (
        output Joystick_data,
        output Fire_btn,
        output Frame_tick,
        output Player_Col,
        output Bullet_ack,
        input  Move_left,
        input  Move_right,
        input  Fire_req,
        input  Fire_col,
        input  Fire_ready
    );
endinterface

// File: rtl/player_ctrl.sv
// Player-ship controller: frame-paced, bounds-checked move pulses plus a
// fire request/acknowledge handshake followed by a frame-counted cooldown.
module player_ctrl #(
    parameter int MOVE_DIV        = 2,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int COL_MIN         = 0,
    parameter int COL_MAX         = 608,
    parameter int HALF_W          = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    player_ctrl_if.master bus
);

    localparam int FRAME_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int COOL_W  = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(MOVE_DIV - 1);
    localparam logic [COOL_W-1:0]  COOL_LAST  = COOL_W'(COOLDOWN_FRAMES - 1);
    localparam logic [9:0]         COL_MIN_C  = 10'(COL_MIN);
    localparam logic [9:0]         COL_MAX_C  = 10'(COL_MAX);
    localparam logic [9:0]         HALF_W_C   = 10'(HALF_W);

    typedef enum logic [1:0] {
        DIR_NEUTRAL = 2'd0,
        DIR_LEFT    = 2'd1,
        DIR_RIGHT   = 2'd2
    } dir_e;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_REQ   = 2'd1,
        ST_COOL  = 2'd2
    } fire_state_e;

    function automatic dir_e decode_dir(input logic [3:0] code);
        if (code < 4'd4) begin
            return DIR_LEFT;
        end else if (code > 4'd6) begin
            return DIR_RIGHT;
        end else begin
            return DIR_NEUTRAL;
        end
    endfunction

    dir_e                dir_s;
    logic [FRAME_W-1:0]  frame_cnt_r;
    logic                move_left_r;
    logic                move_right_r;

    fire_state_e         state_r;
    logic [COOL_W-1:0]   cool_cnt_r;
    logic                fire_q_r;
    logic                fire_rise_r;
    logic                fire_req_r;
    logic [9:0]          fire_col_r;
    logic                fire_ready_r;

    assign dir_s = decode_dir(bus.Joystick_data);

    // Move scheduler: one bounds-checked step every MOVE_DIV frame ticks
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_cnt_r  <= {FRAME_W{1'b0}};
            move_left_r  <= 1'b0;
            move_right_r <= 1'b0;
        end else begin
            move_left_r  <= 1'b0;
            move_right_r <= 1'b0;
            if (bus.Frame_tick) begin
                if (frame_cnt_r == FRAME_LAST) begin
                    frame_cnt_r  <= {FRAME_W{1'b0}};
                    move_left_r  <= (dir_s == DIR_LEFT)  && (bus.Player_Col > COL_MIN_C);
                    move_right_r <= (dir_s == DIR_RIGHT) && (bus.Player_Col < COL_MAX_C);
                end else begin
                    frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
                end
            end
        end
    end

    // Fire button edge detect; the rise is registered so the FSM acts one
    // cycle after the press has been captured in fire_q_r
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fire_q_r    <= 1'b0;
            fire_rise_r <= 1'b0;
        end else begin
            fire_q_r    <= bus.Fire_btn;
            fire_rise_r <= bus.Fire_btn & ~fire_q_r;
        end
    end

    // Fire FSM: READY -> REQ (hold until ack) -> COOL (count frames) -> READY
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r      <= ST_READY;
            cool_cnt_r   <= {COOL_W{1'b0}};
            fire_req_r   <= 1'b0;
            fire_col_r   <= 10'd0;
            fire_ready_r <= 1'b1;
        end else begin
            case (state_r)
                ST_READY: begin
                    if (fire_rise_r) begin
                        state_r      <= ST_REQ;
                        fire_req_r   <= 1'b1;
                        fire_col_r   <= bus.Player_Col + HALF_W_C;
                        fire_ready_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // A frame tick arriving with the ack is deliberately not counted
                    if (bus.Bullet_ack) begin
                        state_r    <= ST_COOL;
                        fire_req_r <= 1'b0;
                        cool_cnt_r <= {COOL_W{1'b0}};
                    end
                end
                ST_COOL: begin
                    if (bus.Frame_tick) begin
                        if (cool_cnt_r == COOL_LAST) begin
                            state_r      <= ST_READY;
                            fire_ready_r <= 1'b1;
                            cool_cnt_r   <= {COOL_W{1'b0}};
                        end else begin
                            cool_cnt_r <= cool_cnt_r + COOL_W'(1);
                        end
                    end
                end
                default: begin
                    state_r      <= ST_READY;
                    cool_cnt_r   <= {COOL_W{1'b0}};
                    fire_req_r   <= 1'b0;
                    fire_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Move_left  = move_left_r;
    assign bus.Move_right = move_right_r;
    assign bus.Fire_req   = fire_req_r;
    assign bus.Fire_col   = fire_col_r;
    assign bus.Fire_ready = fire_ready_r;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed self-checking bench for player_ctrl: movement pacing and bounds,
// fire handshake, cooldown, re-fire rules and asynchronous reset.
module tb_player_ctrl;

    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_err;

    player_ctrl_if bus ();

    player_ctrl #(
        .MOVE_DIV        (2),
        .COOLDOWN_FRAMES (30),
        .COL_MIN         (0),
        .COL_MAX         (608),
        .HALF_W          (16)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Issue n frame ticks; with MOVE_DIV=2 a pulse is due on every even tick
    task automatic do_frames(input string tag, input int n, input logic exp_l, input logic exp_r,
                             output int nl, output int nr);
        nl = 0;
        nr = 0;
        for (int i = 1; i <= n; i++) begin
            bus.Frame_tick = 1'b1;
            step();
            bus.Frame_tick = 1'b0;
            check({tag, "_left"},  32'(bus.Move_left),  32'(exp_l && (i % 2 == 0)));
            check({tag, "_right"}, 32'(bus.Move_right), 32'(exp_r && (i % 2 == 0)));
            nl += int'(bus.Move_left);
            nr += int'(bus.Move_right);
            step();
            check({tag, "_width"}, 32'({bus.Move_left, bus.Move_right}), 32'd0);
        end
    endtask

    initial begin
        int nl;
        int nr;
        n_cmp = 0;
        n_err = 0;
        Reset              = 1'b1;
        bus.Joystick_data  = 4'd5;
        bus.Fire_btn       = 1'b0;
        bus.Frame_tick     = 1'b0;
        bus.Player_Col     = 10'd300;
        bus.Bullet_ack     = 1'b0;
        repeat (3) step();
        check("rst_move_left",  32'(bus.Move_left),  32'd0);
        check("rst_move_right", 32'(bus.Move_right), 32'd0);
        check("rst_fire_req",   32'(bus.Fire_req),   32'd0);
        check("rst_fire_col",   32'(bus.Fire_col),   32'd0);
        check("rst_fire_ready", 32'(bus.Fire_ready), 32'd1);
        Reset = 1'b0;
        repeat (2) step();

        // Neutral joystick: no movement at all
        do_frames("neutral", 10, 1'b0, 1'b0, nl, nr);
        check("neutral_count", 32'(nl + nr), 32'd0);
        check("neutral_fire_req", 32'(bus.Fire_req), 32'd0);

        bus.Joystick_data = 4'd7;
        do_frames("right", 6, 1'b0, 1'b1, nl, nr);
        check("right_count", 32'(nr), 32'd3);

        bus.Joystick_data = 4'd3;
        do_frames("left", 6, 1'b1, 1'b0, nl, nr);
        check("left_count", 32'(nl), 32'd3);

        // Boundaries and one step inside them
        bus.Player_Col = 10'd608;
        bus.Joystick_data = 4'd9;
        do_frames("bound_right", 4, 1'b0, 1'b0, nl, nr);
        bus.Player_Col = 10'd607;
        do_frames("inside_right", 2, 1'b0, 1'b1, nl, nr);
        bus.Player_Col = 10'd0;
        bus.Joystick_data = 4'd0;
        do_frames("bound_left", 4, 1'b0, 1'b0, nl, nr);
        bus.Player_Col = 10'd1;
        do_frames("inside_left", 2, 1'b1, 1'b0, nl, nr);

        // Fire request: two cycles after the button goes high
        bus.Joystick_data = 4'd5;
        bus.Player_Col = 10'd200;
        bus.Fire_btn = 1'b1;
        step();
        check("req_latency_early", 32'(bus.Fire_req), 32'd0);
        step();
        check("req_rise",  32'(bus.Fire_req),   32'd1);
        check("req_col",   32'(bus.Fire_col),   32'd216);
        check("req_ready", 32'(bus.Fire_ready), 32'd0);
        bus.Player_Col = 10'd250;
        repeat (20) step();
        check("req_held",     32'(bus.Fire_req), 32'd1);
        check("req_col_held", 32'(bus.Fire_col), 32'd216);

        // Ack coincides with a frame tick, which must not count
        bus.Bullet_ack = 1'b1;
        bus.Frame_tick = 1'b1;
        step();
        bus.Bullet_ack = 1'b0;
        bus.Frame_tick = 1'b0;
        check("ack_drop",  32'(bus.Fire_req),   32'd0);
        check("ack_ready", 32'(bus.Fire_ready), 32'd0);

        for (int k = 1; k <= 29; k++) begin
            bus.Frame_tick = 1'b1;
            step();
            bus.Frame_tick = 1'b0;
            check("cool_ready", 32'(bus.Fire_ready), 32'd0);
            step();
            if (k == 15) begin
                bus.Fire_btn = 1'b0;
                step();
                bus.Fire_btn = 1'b1;
                repeat (3) step();
                check("press_in_cool", 32'(bus.Fire_req), 32'd0);
            end
        end
        bus.Frame_tick = 1'b1;
        step();
        bus.Frame_tick = 1'b0;
        check("cool_done_ready", 32'(bus.Fire_ready), 32'd1);
        repeat (3) step();
        check("held_no_refire", 32'(bus.Fire_req), 32'd0);

        // Stray ack outside a request
        bus.Bullet_ack = 1'b1;
        step();
        bus.Bullet_ack = 1'b0;
        check("stray_ack_ready", 32'(bus.Fire_ready), 32'd1);
        check("stray_ack_req",   32'(bus.Fire_req),   32'd0);

        // Fresh press after cooldown
        bus.Fire_btn = 1'b0;
        step();
        bus.Player_Col = 10'd100;
        bus.Fire_btn = 1'b1;
        repeat (2) step();
        check("second_req", 32'(bus.Fire_req), 32'd1);
        check("second_col", 32'(bus.Fire_col), 32'd116);

        // Asynchronous reset mid-request
        #3;
        Reset = 1'b1;
        bus.Fire_btn = 1'b0;
        #1;
        check("arst_req_fire_req",   32'(bus.Fire_req),   32'd0);
        check("arst_req_fire_col",   32'(bus.Fire_col),   32'd0);
        check("arst_req_fire_ready", 32'(bus.Fire_ready), 32'd1);
        step();
        Reset = 1'b0;
        step();

        // Muzzle column wraps at 10 bits
        bus.Player_Col = 10'd1020;
        bus.Fire_btn = 1'b1;
        repeat (2) step();
        check("wrap_col", 32'(bus.Fire_col), 32'd12);
        bus.Bullet_ack = 1'b1;
        step();
        bus.Bullet_ack = 1'b0;
        check("wrap_ack", 32'(bus.Fire_req), 32'd0);
        for (int k = 0; k < 3; k++) begin
            bus.Frame_tick = 1'b1;
            step();
            bus.Frame_tick = 1'b0;
            step();
        end
        check("mid_cool_ready", 32'(bus.Fire_ready), 32'd0);

        // Asynchronous reset mid-cooldown
        #2;
        Reset = 1'b1;
        bus.Fire_btn = 1'b0;
        #1;
        check("arst_cool_ready", 32'(bus.Fire_ready), 32'd1);
        check("arst_cool_req",   32'(bus.Fire_req),   32'd0);
        step();
        Reset = 1'b0;
        repeat (2) step();
        check("post_rst_ready", 32'(bus.Fire_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
